// File: rtl/cu_microsequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cu_microsequencer: micro-address sequencer with dispatch, jump, call/ret.  |
// | Optional CU_SEQ_COND_EN adds conditional branch (bcc/cond). Rev 1.0        |
// +----------------------------------------------------------------------------+
module cu_microsequencer #(
  parameter int OPCODE_BITS     = 2,
  parameter int N               = 4,
  parameter int FETCH_ADDR      = 0,
  parameter int DISPATCH_BASE   = 3,
  parameter int DISPATCH_STRIDE = 2,
  parameter int STACK_DEPTH     = 2
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   restart,
  input  logic                   load,
  input  logic                   inc,
  input  logic                   jmp,
  input  logic                   call,
  input  logic                   ret,
`ifdef CU_SEQ_COND_EN
  input  logic                   bcc,
  input  logic                   cond,
`endif
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [N-1:0]           target,
  output logic [N-1:0]           q,
  output logic                   stack_empty,
  output logic                   stack_full,
  output logic                   err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int DW  = N + OPCODE_BITS + 1;
  localparam logic [SPW-1:0] c_sp_full     = SPW'(STACK_DEPTH);
  localparam logic [N-1:0]   c_fetch       = N'(FETCH_ADDR);
  localparam logic [DW-1:0]  c_disp_base   = DW'(DISPATCH_BASE);
  localparam logic [DW-1:0]  c_disp_stride = DW'(DISPATCH_STRIDE);

  logic [N-1:0]   r_q;
  logic [SPW-1:0] r_sp;
  logic           r_err;
  logic [N-1:0]   r_stack [STACK_DEPTH];

  logic [N-1:0]   w_q_nxt;
  logic [N-1:0]   w_q_inc;
  logic [N-1:0]   w_top;
  logic [SPW-1:0] w_sp_nxt;
  logic           w_err_nxt;
  logic           w_push;
  logic           w_empty;
  logic           w_full;
  logic [DW-1:0]  w_disp;

  assign w_q_inc = r_q + N'(1);
  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == c_sp_full);
  // Dispatch is computed wide enough to never overflow, then truncated to N bits.
  assign w_disp  = c_disp_base + DW'(opcode) * c_disp_stride;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
    end
  end

  always_comb begin
    w_q_nxt   = r_q;
    w_sp_nxt  = r_sp;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (restart) begin
      w_q_nxt  = c_fetch;
      w_sp_nxt = '0;
    end else if (ret) begin
      if (w_empty) begin
        w_q_nxt   = c_fetch;
        w_err_nxt = 1'b1;
      end else begin
        w_q_nxt  = w_top;
        w_sp_nxt = r_sp - SPW'(1);
      end
    end else if (call) begin
      if (w_full) begin
        w_err_nxt = 1'b1;
      end else begin
        w_push   = 1'b1;
        w_q_nxt  = target;
        w_sp_nxt = r_sp + SPW'(1);
      end
    end else if (jmp) begin
      w_q_nxt = target;
`ifdef CU_SEQ_COND_EN
    end else if (bcc) begin
      w_q_nxt = cond ? target : w_q_inc;
`endif
    end else if (load) begin
      w_q_nxt = w_disp[N-1:0];
    end else if (inc) begin
      w_q_nxt = w_q_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_q   <= c_fetch;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Stack contents are never reset; only the pointer defines validity.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
    always_ff @(posedge clk) begin
      if (clr_n && w_push && (r_sp == SPW'(gi))) r_stack[gi] <= w_q_inc;
    end
  end

  assign q           = r_q;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cu_microsequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cu_microsequencer: directed bench with queue-based reference model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cu_microsequencer;
  localparam int MOD   = 16;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       clr_n, restart, load, inc, jmp, call, ret, bcc, cond;
  logic [1:0] opcode;
  logic [3:0] target;
  logic [3:0] q;
  logic       stack_empty, stack_full, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cu_microsequencer dut (
    .clk(clk), .clr_n(clr_n), .restart(restart), .load(load), .inc(inc),
    .jmp(jmp), .call(call), .ret(ret),
`ifdef CU_SEQ_COND_EN
    .bcc(bcc), .cond(cond),
`endif
    .opcode(opcode), .target(target), .q(q),
    .stack_empty(stack_empty), .stack_full(stack_full), .err(err)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one prioritised action per edge, return stack as a queue.
  int  m_q;
  int  m_stk[$];
  bit  m_err;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    if (!clr_n) begin
      m_q = 0; m_stk.delete(); m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (restart) begin
        m_q = 0; m_stk.delete();
      end else if (ret) begin
        if (m_stk.size() == 0) begin m_q = 0; m_err = 1'b1; end
        else m_q = m_stk.pop_back();
      end else if (call) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else begin m_stk.push_back((m_q + 1) % MOD); m_q = int'(target); end
      end else if (jmp) m_q = int'(target);
`ifdef CU_SEQ_COND_EN
      else if (bcc) m_q = cond ? int'(target) : (m_q + 1) % MOD;
`endif
      else if (load) m_q = (3 + int'(opcode) * 2) % MOD;
      else if (inc)  m_q = (m_q + 1) % MOD;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), m_q);
      check("model_empty", int'(stack_empty), int'(m_stk.size() == 0));
      check("model_full", int'(stack_full), int'(m_stk.size() == DEPTH));
      check("model_err", int'(err), int'(m_err));
    end
  end

  task automatic clear_cmds();
    restart = 0; load = 0; inc = 0; jmp = 0; call = 0; ret = 0;
    bcc = 0; cond = 0; opcode = '0; target = '0;
  endtask

  // Drive a command for one edge; return 1 time unit after that edge.
  task automatic cmd(input bit rs, input bit rt, input bit cl, input bit jp,
                     input bit ld, input bit ic, input int op, input int tg,
                     input bit b, input bit c);
    restart = rs; ret = rt; call = cl; jmp = jp; load = ld; inc = ic;
    opcode = 2'(op); target = 4'(tg); bcc = b; cond = c;
    @(posedge clk); #1;
    clear_cmds();
  endtask

  task automatic reset_cycles(input int n);
    clr_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    clear_cmds();
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", int'(q), 0);
    check("rst_empty", int'(stack_empty), 1);
    check("rst_full", int'(stack_full), 0);
    check("rst_err", int'(err), 0);
    clr_n = 1'b1;
    @(posedge clk); #1;
    check("idle_q", int'(q), 0);

    // 2: dispatch then increment with wrap
    cmd(0,0,0,0,1,0, 0,0, 0,0); check("load0", int'(q), 3);
    cmd(0,0,0,0,1,0, 1,0, 0,0); check("load1", int'(q), 5);
    cmd(0,0,0,0,1,0, 2,0, 0,0); check("load2", int'(q), 7);
    cmd(0,0,0,0,1,0, 3,0, 0,0); check("load3", int'(q), 9);
    for (int i = 0; i < 6; i++) cmd(0,0,0,0,0,1, 0,0, 0,0);
    check("inc_15", int'(q), 15);
    cmd(0,0,0,0,0,1, 0,0, 0,0); check("inc_wrap", int'(q), 0);

    // 3: nested call / return
    cmd(0,0,0,1,0,0, 0,4, 0,0);  check("jmp4", int'(q), 4);
    cmd(0,0,1,0,0,0, 0,10, 0,0); check("call10_q", int'(q), 10);
    check("call10_empty", int'(stack_empty), 0);
    cmd(0,0,1,0,0,0, 0,12, 0,0); check("call12_q", int'(q), 12);
    check("call12_full", int'(stack_full), 1);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("ret_11", int'(q), 11);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("ret_5", int'(q), 5);
    check("ret_empty", int'(stack_empty), 1);
    check("no_err_yet", int'(err), 0);

    // 4: overflow then underflow
    cmd(0,0,0,1,0,0, 0,4, 0,0);
    cmd(0,0,1,0,0,0, 0,10, 0,0);
    cmd(0,0,1,0,0,0, 0,12, 0,0);
    cmd(0,0,1,0,0,0, 0,1, 0,0);  check("ovf_q", int'(q), 12);
    check("ovf_err", int'(err), 1);
    check("ovf_full", int'(stack_full), 1);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("ovf_ret11", int'(q), 11);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("ovf_ret5", int'(q), 5);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("udf_q", int'(q), 0);
    check("udf_err", int'(err), 1);

    // 5: priority among simultaneous commands
    cmd(0,0,0,1,0,0, 0,4, 0,0);
    cmd(0,0,1,0,0,0, 0,10, 0,0);
    cmd(0,1,1,0,1,0, 2,7, 0,0);  check("prio_ret_q", int'(q), 5);
    check("prio_ret_empty", int'(stack_empty), 1);
    cmd(0,0,1,0,0,0, 0,10, 0,0);
    cmd(1,1,0,0,0,0, 0,0, 0,0);  check("restart_q", int'(q), 0);
    check("restart_empty", int'(stack_empty), 1);
    check("restart_keeps_err", int'(err), 1);

    // Reset mid-subroutine: stack discarded, return underflows
    reset_cycles(1);
    check("rst2_err", int'(err), 0);
    cmd(0,0,0,1,0,0, 0,4, 0,0);
    cmd(0,0,1,0,0,0, 0,9, 0,0);  check("sub_q", int'(q), 9);
    reset_cycles(1);
    check("rst3_empty", int'(stack_empty), 1);
    cmd(0,1,0,0,0,0, 0,0, 0,0);  check("post_rst_ret_q", int'(q), 0);
    check("post_rst_ret_err", int'(err), 1);

`ifdef CU_SEQ_COND_EN
    // 6: conditional branch
    cmd(0,0,0,1,0,0, 0,6, 0,0);
    cmd(0,0,0,0,0,0, 0,2, 1,1);  check("bcc_taken", int'(q), 2);
    cmd(0,0,0,0,0,0, 0,2, 1,0);  check("bcc_not_taken", int'(q), 3);
    cmd(0,0,0,0,1,0, 0,8, 1,1);  check("bcc_over_load", int'(q), 8);
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
